// File: rtl/phy_pkg.sv
// Shared definitions for the phy lane receive path: alignment FSM state
// encoding and default COM symbol / sync depth.
package phy_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } sp_state_t;

    localparam logic [7:0] COM_8B         = 8'hBC;
    localparam int         SYNC_COUNT_DEF = 4;

endpackage

// File: rtl/phy_align_fsm.sv
// Word-alignment FSM for the serial deserializer: hunts for COM at any bit
// offset, confirms SYNC_COUNT aligned COM words, then tracks word boundaries.
module phy_align_fsm
    import phy_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SYNC_COUNT = SYNC_COUNT_DEF
) (
    input  logic      clk_32f,
    input  logic      reset,
    input  logic      com_match,
    output logic      word_done,
    output sp_state_t state
);

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SCW = $clog2(SYNC_COUNT + 1);

    localparam logic [BCW-1:0] BIT_LAST   = BCW'(WIDTH - 1);
    localparam logic [SCW-1:0] SYNC_LAST  = SCW'(SYNC_COUNT - 1);
    localparam sp_state_t      LOCK_STATE = (SYNC_COUNT == 1) ? ACTIVE : SYNC;

    sp_state_t      state_n;
    logic [BCW-1:0] bit_cnt, bit_cnt_n;
    logic [SCW-1:0] sync_cnt, sync_cnt_n;

    // A word completes only on the last bit of an aligned word; HUNT has no boundary.
    assign word_done = (state != HUNT) && (bit_cnt == BIT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state    <= HUNT;
            bit_cnt  <= '0;
            sync_cnt <= '0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            sync_cnt <= sync_cnt_n;
        end
    end

    // NOTE: every next-state variable is given a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        sync_cnt_n = sync_cnt;

        unique case (state)
            HUNT: begin
                if (com_match) begin
                    bit_cnt_n  = '0;
                    sync_cnt_n = SCW'(1);
                    state_n    = LOCK_STATE;
                end
            end

            SYNC: begin
                bit_cnt_n = word_done ? '0 : bit_cnt + 1'b1;
                if (word_done) begin
                    if (com_match) begin
                        sync_cnt_n = sync_cnt + 1'b1;
                        if (sync_cnt == SYNC_LAST) begin
                            state_n = ACTIVE;
                        end
                    end else begin
                        // Back to hunting on the next edge; the shift register keeps its bits.
                        state_n    = HUNT;
                        sync_cnt_n = '0;
                        bit_cnt_n  = '0;
                    end
                end
            end

            ACTIVE: begin
                bit_cnt_n = word_done ? '0 : bit_cnt + 1'b1;
            end

            default: begin
                state_n    = HUNT;
                bit_cnt_n  = '0;
                sync_cnt_n = '0;
            end
        endcase
    end

endmodule

// File: rtl/serial_paralelo_sync.sv
// Receive-side serial-to-parallel stage with COM hunting and word alignment.
// Optional word counter enabled by defining SP_WORD_CNT_EN.
module serial_paralelo_sync
    import phy_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM        = WIDTH'(COM_8B),
    parameter int               SYNC_COUNT = SYNC_COUNT_DEF
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             word_strobe,
    output logic             active
`ifdef SP_WORD_CNT_EN
    ,
    output logic [15:0]      word_count
`endif
);

    // Only the WIDTH-1 older bits need storing; the newest bit is data_in itself.
    logic [WIDTH-2:0] sr;
    logic [WIDTH-1:0] w;
    logic             com_match;
    logic             word_done;
    sp_state_t        state;

    assign w         = {sr, data_in};
    assign com_match = (w == COM);
    assign active    = (state == ACTIVE);

    phy_align_fsm #(
        .WIDTH      (WIDTH),
        .SYNC_COUNT (SYNC_COUNT)
    ) u_align_fsm (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .com_match (com_match),
        .word_done (word_done),
        .state     (state)
    );

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            sr          <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            word_strobe <= 1'b0;
        end else begin
            sr          <= w[WIDTH-2:0];
            word_strobe <= word_done;
            if (word_done && state == ACTIVE) begin
                if (com_match) begin
                    valid_out <= 1'b0;
                end else begin
                    valid_out <= 1'b1;
                    data_out  <= w;
                end
            end
        end
    end

`ifdef SP_WORD_CNT_EN
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            word_count <= '0;
        end else if (word_done && state == ACTIVE && !com_match &&
                     word_count != 16'hFFFF) begin
            word_count <= word_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/serial_paralelo_sync.md
Name: serial_paralelo_sync

Overview:
Parametrised receive-side deserializer for the phy lane.
- Takes one serial bit per clk_32f and hunts for the COM symbol at any bit offset.
- Locks word alignment after SYNC_COUNT consecutive aligned COM words, then emits parallel words with a valid flag; COM words are treated as idle.
- Generalises the fixed 8-bit, 0xBC, 4-COM serial-to-parallel stage: width, COM pattern and sync depth are parameters, and bit-slip hunting is added.

Parameters:
WIDTH, 8, parallel word width in bits (>=4).
COM, 8'hBC (WIDTH bits), idle/alignment symbol.
SYNC_COUNT, 4, consecutive aligned COM words required to enter ACTIVE (>=1).

Ports:
clk_32f  input  1  bit clock; all logic on rising edge.
reset  input  1  asynchronous, active-high; clears all state.
data_in  input  1  serial data, MSB of each word first.
data_out  output  WIDTH  last received non-COM word.
valid_out  output  1  high for words received in ACTIVE that are not COM.
word_strobe  output  1  one-cycle pulse per aligned word boundary.
active  output  1  high while in ACTIVE.

Behaviour:
- Reset: data_out=0, valid_out=0, word_strobe=0, active=0, state=HUNT, bit_cnt=0, sync_cnt=0, shift register=0.
- Every edge shifts data_in into sr (WIDTH bits, LSB side).
- Candidate word w = {sr[WIDTH-2:0], data_in}.
- HUNT:
  - Compare w against COM on every edge.
  - On match: bit_cnt<=0 (word boundary) and sync_cnt<=1.
  - Next state is ACTIVE if SYNC_COUNT==1, otherwise SYNC.
- Aligned operation (SYNC, ACTIVE):
  - bit_cnt counts 0..WIDTH-1 and wraps.
  - A word completes on the edge where bit_cnt==WIDTH-1; w is evaluated on that edge only.
- SYNC:
  - Completed w==COM: sync_cnt++; when sync_cnt reaches SYNC_COUNT, go to ACTIVE and set active<=1 on the same edge.
  - Completed w!=COM: go to HUNT with sync_cnt<=0. Hunting resumes on the very next edge; no bits are discarded.
- ACTIVE:
  - Completed w!=COM: data_out<=w, valid_out<=1.
  - Completed w==COM: valid_out<=0; data_out holds its previous value.
  - ACTIVE is left only by reset.
- Timing of registered outputs:
  - word_strobe is 1 for the single cycle after each completed word in SYNC/ACTIVE, else 0.
  - valid_out and data_out change only on word-completion edges and are held between them.
- Latency: outputs reflect a word one clk_32f after its last bit is sampled.
- Boundaries:
  - A COM-pattern match at a non-boundary bit position while in SYNC/ACTIVE is ignored; there is no realignment once aligned.
  - Reset asserted mid-word clears everything immediately, including the partial word.
  - No loss-of-sync detection in ACTIVE.

Optional Feature:
Macro SP_WORD_CNT_EN.
- Defined: adds output word_count [15:0], reset 0.
  - Increments on every edge that sets valid_out<=1.
  - Saturates at 16'hFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package phy_pkg:
  - state encoding typedef/localparams HUNT=0, SYNC=1, ACTIVE=2;
  - default COM_8B=8'hBC;
  - default SYNC_COUNT_DEF=4.
- No sub-module is required; the shift/compare and FSM fit in one module.
- Optionally, a sub-module phy_align_fsm holds state, sync_cnt and bit_cnt.

Test Plan:
- Reset: assert reset mid-stream -> all outputs 0 on the same cycle; state HUNT; active=0.
- Lock at offset: 3 junk bits 101, then 4x 0xBC -> active=1 one clk after the 32nd COM bit; 3 word_strobe pulses during SYNC, and at least 1 after lock; valid_out=0 throughout.
- Data path: after lock send 0x5A, 0xBC, 0xC3 -> valid_out=1 and data_out=0x5A; then valid_out=0 with data_out held at 0x5A; then valid_out=1 and data_out=0xC3. Each update occurs 1 clk after the word's last bit.
- Sync abort: 2x 0xBC, then 0x00, then 4x 0xBC -> return to HUNT after 0x00, active stays 0, then lock on the later COMs.
- Parameter instance: WIDTH=10, COM=10'h17C, SYNC_COUNT=1 -> active=1 one clk after the first COM; word_strobe period 10 clk.
- SP_WORD_CNT_EN: 70000 data words after lock -> word_count saturates at 16'hFFFF; COM words are not counted.
